// File: rtl/mips_rf_pkg.sv
// Shared types and default sizes for the MIPS general-purpose register file.
package mips_rf_pkg;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;

endpackage

// File: rtl/rf_cell.sv
// One register-file word: async active-low reset, write enable, synchronous clear.
module rf_cell
    import mips_rf_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear takes priority over a write so a sweep always leaves the word at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mips_reg_file.sv
// General-purpose register file: two combinational read ports with write bypass,
// one synchronous write port, optional hardwired r0 and a one-word-per-cycle clear sweep.
module mips_reg_file
    import mips_rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              clr_req,
    output logic              busy
);

    rf_state_t         state;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  q [DEPTH];

    // Sweep sequencer: IDLE accepts a clear request, CLEAR zeroes one word per edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RF_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                RF_IDLE: begin
                    if (clr_req) begin
                        state <= RF_CLEAR;
                        cnt   <= '0;
                    end
                end
                RF_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= RF_IDLE;
                    end
                end
                default: begin
                    state <= RF_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == RF_CLEAR);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        if (i == 0 && ZERO_REG != 0) begin : g_zero
            assign q[i] = '0;
        end else begin : g_reg
            logic cell_en;
            logic cell_clr;
            assign cell_en  = (state == RF_IDLE) && wen && (waddr == ADDR_W'(i));
            assign cell_clr = (state == RF_CLEAR) && (cnt == ADDR_W'(i));
            rf_cell #(
                .WIDTH(WIDTH)
            ) u_cell (
                .clk(clk),
                .rst(rst),
                .en (cell_en),
                .clr(cell_clr),
                .d  (wdata),
                .q  (q[i])
            );
        end
    end

    // Port A read: zero in reset/sweep/r0, otherwise bypass a same-cycle write or read storage.
    always_comb begin
        rdata_a = '0;
        if (rst && state == RF_IDLE && !(ZERO_REG != 0 && raddr_a == '0)) begin
            if (wen && raddr_a == waddr) begin
                rdata_a = wdata;
            end else begin
                rdata_a = q[raddr_a];
            end
        end
    end

    // Port B read: same rules as port A, evaluated independently.
    always_comb begin
        rdata_b = '0;
        if (rst && state == RF_IDLE && !(ZERO_REG != 0 && raddr_b == '0)) begin
            if (wen && raddr_b == waddr) begin
                rdata_b = wdata;
            end else begin
                rdata_b = q[raddr_b];
            end
        end
    end

endmodule
